seq_piso_tx: RTL
================

# seq_piso_tx

Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock, MSB first, with a qualifying strobe. It is the transmit end for the team's serial-in shift register, which shifts `srin` into the LSB every clock. Driving `sout` into that register's serial input for the WIDTH strobed cycles of a frame reassembles the original word in it.

## Interface
- `WIDTH`, default 8: data word width in bits; legal range 2..32.
- `clk` input 1: clock for all flip-flops, rising edge.
- `rst` input 1: reset, synchronous, active-high; sampled on the rising edge of `clk`.
- `din` input WIDTH: parallel word to transmit.
- `din_valid` input 1: `din` is valid this cycle.
- `din_ready` output 1: block can accept a word this cycle. A transfer occurs when `din_valid && din_ready` at a rising edge.
- `sout` output 1: serial data bit.
- `sout_valid` output 1: `sout` carries a frame bit this cycle.
- `sout_last` output 1: this is the final bit of the frame.
- `busy` output 1: a frame is in progress (state != IDLE).

## Operation
- FSM states: IDLE, SHIFT, and PARITY (PARITY only when `PARITY_EN` is defined).
- IDLE:
  - `din_ready`=1; `sout`=0, `sout_valid`=0, `sout_last`=0.
  - On transfer: load `din` into the shift register, set bit counter = WIDTH-1, go to SHIFT.
- SHIFT:
  - `sout` = shift_reg[WIDTH-1]; `sout_valid`=1.
  - Each cycle: shift left by one (zero fill) and decrement the counter.
  - `sout_last`=1 when counter==0 and parity is disabled.
  - At counter==0: go to PARITY if enabled. Otherwise, go to SHIFT with a new word if a transfer occurs, else go to IDLE.
- PARITY: `sout` = latched parity bit; `sout_valid`=1, `sout_last`=1. Next state is SHIFT if a transfer occurs, else IDLE.
- `din_ready` is combinational from state and counter. It is 1 in IDLE and in the final-bit cycle of a frame (SHIFT with counter==0 when parity is disabled, PARITY when enabled). This allows back-to-back frames with no gap.
- `din_valid` while `din_ready`=0 is ignored; upstream holds `din`. `din` is sampled only at a transfer.
- Counter width: $clog2(WIDTH). The counter never wraps below 0; the terminal state decides the next state.
- `rst` high at an edge forces IDLE, shift_reg=0, counter=0 and parity=0 regardless of other inputs.
  - A frame in progress is aborted and the partial frame is discarded.
  - `sout`, `sout_valid` and `sout_last` are 0 from the first edge with `rst` high.
- `din_ready`=0 while `rst` is high.

## Timing
- All outputs are driven from registered state; `din_ready` is combinational from state only, never from `din_valid`.
- Reset values: `sout`=0, `sout_valid`=0, `sout_last`=0, `busy`=0, `din_ready`=1 once `rst` deasserts.
- Transfer at edge N: the MSB is on `sout` in cycle N+1 and bit i (MSB=WIDTH-1) is in cycle N+WIDTH-i.
- Without parity: last data bit in cycle N+WIDTH, with `sout_last`=1.
- With parity: parity bit in cycle N+WIDTH+1, with `sout_last`=1.
- Frame lengths: WIDTH cycles without parity, WIDTH+1 cycles with parity. Sustained throughput is one word per frame length with no idle cycles.
- Transfer on the last-bit edge: the next frame's MSB follows in the immediately next cycle.

## Configuration
- `SEQ_PISO_PARITY_EN` defined: one even-parity bit (^`din`, latched at load) is appended after the LSB; frame length is WIDTH+1.
- `SEQ_PISO_PARITY_EN` undefined: PARITY state, parity register and logic are absent; frame length is WIDTH.

## Structure
- Shared package `seq_pkg`:
  - `typedef enum logic [1:0] {IDLE, SHIFT, PARITY} piso_state_t`.
  - Constant `SEQ_WIDTH_DEFAULT = 8`.
- One natural sub-module: `seq_bitcnt`, a loadable down-counter with a `zero` flag, parameterised by WIDTH. The FSM and shift register stay in `seq_piso_tx`.

## Test plan
- Reset, then `din`=8'hA5 with `din_valid` pulsed at edge N -> `sout` = 1,0,1,0,0,1,0,1 in cycles N+1..N+8; `sout_valid`=1 throughout; `sout_last` only at N+8. A receiving SIPO register holds 8'hA5 after N+8.
- Back-to-back 8'hFF then 8'h01 with `din_valid` held -> 16 contiguous strobed bits 11111111_00000001; `din_ready` high only in IDLE and cycle N+8; no gap between frames.
- `din_valid` asserted mid-frame with `din`=8'h3C -> ignored until the last-bit cycle; the word is accepted then and transmitted next.
- `rst` asserted in cycle N+4 of an 8'hA5 frame -> next cycle `sout_valid`=0, `busy`=0; after release a new word 8'h81 transmits cleanly as 1,0,0,0,0,0,0,1.
- With `SEQ_PISO_PARITY_EN`: 8'h07 -> 8 data bits then parity bit 1 in cycle N+9 with `sout_last`=1; 8'h03 -> parity bit 0.
- WIDTH=2: 2'b10 -> `sout` = 1,0 and `din_ready` in the second bit cycle; the counter never wraps.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the seq_* serial blocks.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } piso_state_t;

  localparam int SEQ_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/seq_piso_tx_if.sv
// Parallel load handshake plus serial output bundle for seq_piso_tx.
interface seq_piso_tx_if #(
  parameter int WIDTH = seq_pkg::SEQ_WIDTH_DEFAULT
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_last;
  logic             busy;

  // master: upstream word source / serial consumer; slave: the transmitter
  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, sout_last, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, sout_last, busy
  );
endinterface

// File: rtl/seq_bitcnt.sv
// Loadable down-counter for the bits remaining in a frame; saturates at zero.
module seq_bitcnt #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                      cnt <= '0;
    else if (load)                cnt <= CW'(WIDTH - 1);
    else if (dec && cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/seq_piso_tx.sv
// PISO transmitter: MSB-first serialiser with valid/ready load.
// Define SEQ_PISO_PARITY_EN to append an even-parity bit after the LSB.
module seq_piso_tx
  import seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  seq_piso_tx_if.slave bus
);

  piso_state_t      state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             load, dec, zero, xfer;
`ifdef SEQ_PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  seq_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .dec  (dec),
    .zero (zero)
  );

  // Ready only in IDLE and the final bit cycle, so frames can abut.
  always_comb begin
    bus.din_ready = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:   bus.din_ready = 1'b1;
`ifdef SEQ_PISO_PARITY_EN
        PARITY: bus.din_ready = 1'b1;
`else
        SHIFT:  bus.din_ready = zero;
`endif
        default: bus.din_ready = 1'b0;
      endcase
    end
  end

  assign xfer = bus.din_valid && bus.din_ready;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    load    = 1'b0;
    dec     = 1'b0;
`ifdef SEQ_PISO_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: ;
      SHIFT: begin
        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
        dec    = 1'b1;
`ifdef SEQ_PISO_PARITY_EN
        if (zero) state_d = PARITY;
`else
        if (zero) state_d = IDLE;
`endif
      end
`ifdef SEQ_PISO_PARITY_EN
      PARITY: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
    // xfer can only fire in a terminal cycle, so it always starts a new frame
    if (xfer) begin
      load    = 1'b1;
      sreg_d  = bus.din;
      state_d = SHIFT;
`ifdef SEQ_PISO_PARITY_EN
      par_d   = ^bus.din;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
`ifdef SEQ_PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
`ifdef SEQ_PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    bus.sout       = 1'b0;
    bus.sout_valid = 1'b0;
    bus.sout_last  = 1'b0;
    case (state_q)
      SHIFT: begin
        bus.sout       = sreg_q[WIDTH-1];
        bus.sout_valid = 1'b1;
`ifndef SEQ_PISO_PARITY_EN
        bus.sout_last  = zero;
`endif
      end
`ifdef SEQ_PISO_PARITY_EN
      PARITY: begin
        bus.sout       = par_q;
        bus.sout_valid = 1'b1;
        bus.sout_last  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.busy = (state_q != IDLE);

endmodule
